// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control unit and the downstream ALU control decoder.
// Holds state codes, opcodes, aluop codes, mux-select encodings and the decode-stage dispatch.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMRD    = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWR    = 4'd6,
        ST_RTYPE_EX = 4'd7,
        ST_RTYPE_WB = 4'd8,
        ST_BEQ_EX   = 4'd9,
        ST_ADDI_EX  = 4'd10,
        ST_ADDI_WB  = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch from DECODE; anything unrecognised is trapped.
    function automatic state_t decode_dispatch(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = ST_MEMADR;
            OP_RTYPE:     nxt = ST_RTYPE_EX;
            OP_BEQ:       nxt = ST_BEQ_EX;
            OP_ADDI:      nxt = ST_ADDI_EX;
            OP_J:         nxt = ST_JUMP;
            default:      nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control.sv
// Multicycle MIPS-style main control: Moore FSM stepping fetch/decode/execute/memory/writeback,
// with memory-ready stalls and a retired-instruction counter.
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state selection; memory states hold until mem_ready.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:   state_d = decode_dispatch(opcode);
            ST_MEMADR:   state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWR:    state_d = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_RTYPE_EX: state_d = ST_RTYPE_WB;
            ST_RTYPE_WB: state_d = ST_FETCH;
            ST_BEQ_EX:   state_d = ST_FETCH;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_ADDI_WB:  state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_FETCH;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode from state; only ir_write, pc_write and MEMWR retire look at inputs.
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        aluop      = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            ST_MEMADR, ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            ST_RTYPE_EX: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            ST_RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            ST_BEQ_EX: begin
                alu_src_a  = 1'b1;
                aluop      = ALUOP_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            ST_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            ST_TRAP: begin
                illegal    = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // Retire counter wraps freely.
    always_comb begin
        if (instr_done) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: an expected per-cycle trace built from instruction-level
// descriptions, compared against the DUT every cycle, plus literal pins and a mid-wait reset.
module tb_mc_control;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic        alu_src_a, instr_done, illegal;
    logic [1:0]  alu_src_b, aluop, pc_src;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    mc_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .pc_src(pc_src),
        .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [31:0] cnt;
    } ent_t;

    ent_t        q[$];
    logic [5:0]  cur_op;
    logic        cur_z;
    int          mcount = 0;
    int          tests = 0;
    int          fails = 0;
    int          mw_cycles = 0;
    int          ill_pulses = 0;
    int          done_pulses = 0;

    // {pc_write,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,aluop,pc_src,instr_done,illegal}
    function automatic logic [16:0] cv(input logic pcw, input logic io, input logic mrd,
                                       input logic mwr, input logic irw, input logic rdst,
                                       input logic m2r, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] psrc, input logic done, input logic ill);
        return {pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, done, ill};
    endfunction

    function automatic logic [16:0] dut_ctl();
        return {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, aluop, pc_src, instr_done, illegal};
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic [16:0] ctl);
        ent_t e;
        e.op  = cur_op;
        e.mr  = mr;
        e.z   = cur_z;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = 32'(mcount);
        q.push_back(e);
        if (ctl[1]) mcount = mcount + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests = tests + 1;
        if (got !== want) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, want, $time);
        end
    endtask

    // One instruction: fw cycles of fetch stall, mw cycles of data-memory stall.
    task automatic add_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        cur_op = op;
        cur_z  = z;
        for (int i = 0; i < fw; i++) push(4'd1, 1'b0, cv(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));
        push(4'd1, 1'b1, cv(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0));
        push(4'd2, 1'b0, cv(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0));
        case (op)
            OP_LW: begin
                push(4'd3, 1'b0, cv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
                for (int i = 0; i < mw; i++) push(4'd4, 1'b0, cv(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
                push(4'd4, 1'b1, cv(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
                push(4'd5, 1'b0, cv(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0));
            end
            OP_SW: begin
                push(4'd3, 1'b1, cv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
                for (int i = 0; i < mw; i++) push(4'd6, 1'b0, cv(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
                push(4'd6, 1'b1, cv(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0));
            end
            OP_RTYPE: begin
                push(4'd7, 1'b1, cv(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0));
                push(4'd8, 1'b0, cv(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0));
            end
            OP_BEQ: push(4'd9, 1'b0, cv(z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0));
            OP_ADDI: begin
                push(4'd10, 1'b0, cv(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
                push(4'd11, 1'b1, cv(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0));
            end
            OP_J: push(4'd12, 1'b0, cv(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0));
            default: push(4'd13, 1'b1, cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1));
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        ent_t e;
        add_instr(OP_LW,    1'b0, 0, 0);
        add_instr(OP_SW,    1'b0, 0, 2);
        add_instr(OP_BEQ,   1'b1, 0, 0);
        add_instr(OP_BEQ,   1'b0, 0, 0);
        add_instr(OP_RTYPE, 1'b1, 0, 0);
        add_instr(OP_ADDI,  1'b0, 0, 0);
        add_instr(6'b111111, 1'b0, 0, 0);
        add_instr(OP_J,     1'b0, 0, 0);
        add_instr(OP_LW,    1'b0, 1, 1);

        // Reset state.
        #12;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_ctl", 32'(dut_ctl()), 32'd0);
        check("reset_count", instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed trace, compared every cycle.
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            opcode    = e.op;
            zero      = e.z;
            mem_ready = e.mr;
            @(negedge clk);
            check("state", 32'(state_o), 32'(e.st));
            check("ctl", 32'(dut_ctl()), 32'(e.ctl));
            check("count", instr_count, e.cnt);
            mw_cycles   = mw_cycles + int'(mem_write);
            ill_pulses  = ill_pulses + int'(illegal);
            done_pulses = done_pulses + int'(instr_done);
        end

        // Literal pins on the program as a whole.
        check("sw_mem_write_cycles", 32'(mw_cycles), 32'd3);
        check("illegal_pulses", 32'(ill_pulses), 32'd1);
        check("done_pulses", 32'(done_pulses), 32'd9);

        @(posedge clk);
        #1;
        opcode    = OP_LW;
        mem_ready = 1'b1;
        @(negedge clk);
        check("after_prog_state", 32'(state_o), 32'd1);
        check("after_prog_count", instr_count, 32'd9);

        // Reset during a MEMRD wait.
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("memrd_wait_state", 32'(state_o), 32'd4);
        check("memrd_wait_read", 32'(mem_read), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_state", 32'(state_o), 32'd0);
        check("midreset_ctl", 32'(dut_ctl()), 32'd0);
        check("midreset_count", instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("resume_state", 32'(state_o), 32'd1);
        check("resume_ctl", 32'(dut_ctl()), 32'(cv(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS-style datapath, sitting directly upstream of the ALU control decoder. A Moore state machine steps each instruction through fetch/decode/execute/memory/writeback. It drives every datapath enable, mux select and the 2-bit `aluop` that the ALU control decoder combines with the funct field. It stalls on a memory ready handshake and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction[31:26] from the instruction register; stable from DECODE until the next FETCH completes.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC load enable.
- `iord` out 1: memory address select (0 = PC, 1 = ALU out).
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = MDR, 0 = ALU out.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `aluop` out 2: 00 = add, 01 = subtract, 10 = use funct.
- `pc_src` out 2: 00 = ALU result, 01 = ALU out register, 10 = jump target.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse for an unsupported opcode.
- `instr_count` out CNT_W: number of retired instructions, including illegal ones.
- `state_o` out 4: current state, for debug.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPE_EX=7, RTYPE_WB=8, BEQ_EX=9, ADDI_EX=10, ADDI_WB=11, JUMP=12, TRAP=13.
- Codes 14 and 15 go to IDLE on the next edge.
- Every output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `aluop`=00, `pc_src`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; otherwise goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `aluop`=00 (branch target computed into ALU out). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 -> RTYPE_EX.
  - 000100 (beq) -> BEQ_EX.
  - 001000 (addi) -> ADDI_EX.
  - 000010 (j) -> JUMP.
  - anything else -> TRAP.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Waits for `mem_ready`, then goes to FETCH.
- RTYPE_EX: `alu_src_a`=1, `alu_src_b`=00, `aluop`=10. Goes to RTYPE_WB.
- RTYPE_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BEQ_EX: `alu_src_a`=1, `alu_src_b`=00, `aluop`=01, `pc_src`=01, `pc_write`=`zero`. Goes to FETCH.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `aluop`=00. Goes to ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- JUMP: `pc_src`=10, `pc_write`=1. Goes to FETCH.
- TRAP: `illegal`=1. Goes to FETCH; the PC has already advanced, so the instruction is skipped.
- `instr_done` is 1 in the final state of each instruction:
  - MEMWB, RTYPE_WB, BEQ_EX, ADDI_WB, JUMP and TRAP;
  - MEMWR only in the cycle `mem_ready`=1.
- `instr_count` increments on every edge where `instr_done`=1. It wraps modulo 2^CNT_W and has no saturation.

## Timing
- Reset: the state register goes to IDLE immediately on `rst_n` falling, asynchronously.
  - All control outputs, `instr_done` and `illegal` read 0 while in IDLE.
  - `instr_count` resets to 0; `state_o` resets to 0.
  - Reset asserted mid-instruction (including during a memory wait) abandons the instruction with no write strobes.
- First FETCH occurs on the first edge after `rst_n` deasserts.
- Outputs are decoded from the state register alone. The only exceptions are the `mem_ready`/`zero` qualified outputs (`ir_write`, `pc_write`, MEMWR `instr_done`), which are combinational from those inputs.
- Zero-wait cycle counts, FETCH through retire:
  - lw 5;
  - sw 4, R-type 4, addi 4;
  - beq 3, j 3, illegal 3.
- Each cycle `mem_ready` is held low in FETCH, MEMRD or MEMWR adds exactly one cycle. The strobes stay asserted and unchanged throughout the wait.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.

## Structure
- Shared package `mc_pkg` holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - `aluop` codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), which the ALU control decoder also uses;
  - `alu_src_b` and `pc_src` select encodings.
- Single module containing a next-state process, an output decode process and the retire counter. No sub-module is needed.

## Test plan
- Reset, then lw with `mem_ready` tied 1: states 1,2,3,4,5,1. `reg_write`=`mem_to_reg`=1 in MEMWB only; `instr_count`=1.
- sw with `mem_ready` low for 2 cycles in MEMWR: `mem_write`=`iord`=1 for 3 cycles; `instr_done` pulses once, on the ready cycle.
- beq twice, with `zero`=1 and then `zero`=0: `pc_write`=1 with `pc_src`=01 and `aluop`=01 only in the `zero`=1 case; both retire in 3 cycles.
- R-type then addi: `aluop`=10 in RTYPE_EX with `reg_dst`=1 in RTYPE_WB; addi gives `alu_src_b`=10 with `reg_dst`=0; 8 cycles total.
- Opcode 111111: TRAP, `illegal` pulses for 1 cycle, return to FETCH, `instr_count` increments.
- `rst_n` low during a MEMRD wait: IDLE immediately, all outputs 0, count 0; FETCH resumes after release.
